// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates the instruction-cache miss port and the data-cache miss/writeback
// port onto a single physical memory port. Each port gets at most one
// outstanding transaction. The granted request's address, write data and
// operation are latched, so the memory bus stays stable even if the requester's
// inputs change while the transaction is in flight.
//
// Parameters:
//   LINE_WIDTH   cache line width in bits (default 128)
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   i_read, i_address              instruction-cache miss request
//   i_rdata, i_resp                instruction-cache line and one-cycle response
//   d_read, d_write, d_address,
//   d_wdata                        data-cache miss / writeback request
//   d_rdata, d_resp                data-cache line and one-cycle response
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata       shared physical memory request
//   pmem_rdata, pmem_resp          shared physical memory response
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when this macro is defined, simultaneous requests
//                       alternate between the ports. When it is undefined
//                       (the default), the d port always wins.

module mem_arbiter #(
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_read,
  input  logic [15:0]           i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [15:0]           d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [15:0]           pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [2:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    I_DONE,
    D_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  d_req;
  logic                  grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the d port won the most recent grant.
  logic                  last_d_q, last_d_d;
`endif

  // Grant decision, evaluated only in IDLE. A d request with both read and
  // write high is a write.
  always_comb begin
    d_req = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
    grant_d = d_req & (~i_read | ~last_d_q);
`else
    grant_d = d_req;
`endif
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d  = last_d_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = D_BUSY;
          addr_d   = d_address;
          wdata_d  = d_wdata;
          wr_d     = d_write;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (i_read) begin
          state_d  = I_BUSY;
          addr_d   = i_address;
          wr_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end
      I_BUSY: begin
        if (pmem_resp) begin
          i_rdata_d = pmem_rdata;
          state_d   = I_DONE;
        end
      end
      D_BUSY: begin
        if (pmem_resp) begin
          // A writeback completion leaves the last read line in place.
          if (!wr_q) begin
            d_rdata_d = pmem_rdata;
          end
          state_d = D_DONE;
        end
      end
      I_DONE:  state_d = IDLE;
      D_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      // Pretend i won last so the first simultaneous pair goes to d.
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  always_comb begin
    pmem_read    = (state_q == I_BUSY) | ((state_q == D_BUSY) & ~wr_q);
    pmem_write   = (state_q == D_BUSY) & wr_q;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_resp       = (state_q == I_DONE);
    d_resp       = (state_q == D_DONE);
    i_rdata      = i_rdata_q;
    d_rdata      = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_read = 1'b0;
  logic [15:0]   i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [15:0]   d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int nchecks = 0;
  int nerrors = 0;
  bit chk_en = 1'b0;

  mem_arbiter #(.LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: at most one transaction in flight, described
  // by which port owns it, whether it writes, and whether it is on the bus or
  // delivering its response.
  bit          m_active, m_responding, m_is_d, m_wr, m_last_d;
  logic [15:0] m_addr;
  logic [LW-1:0] m_wdata, m_ir, m_dr;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_responding = 0; m_is_d = 0; m_wr = 0; m_last_d = 0;
      m_addr = '0; m_wdata = '0; m_ir = '0; m_dr = '0;
    end else if (m_responding) begin
      m_active = 0; m_responding = 0;
    end else if (m_active) begin
      if (pmem_resp) begin
        if (!m_is_d) m_ir = pmem_rdata;
        else if (!m_wr) m_dr = pmem_rdata;
        m_responding = 1;
      end
    end else begin
      bit dreq, take_d;
      dreq = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
      take_d = dreq && (!i_read || !m_last_d);
`else
      take_d = dreq;
`endif
      if (take_d) begin
        m_active = 1; m_is_d = 1; m_wr = d_write; m_addr = d_address;
        m_wdata = d_wdata; m_last_d = 1;
      end else if (i_read) begin
        m_active = 1; m_is_d = 0; m_wr = 0; m_addr = i_address; m_last_d = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      bit on_bus;
      on_bus = m_active && !m_responding;
      check("pmem_read",    LW'(pmem_read),  LW'(on_bus && !m_wr));
      check("pmem_write",   LW'(pmem_write), LW'(on_bus && m_wr));
      check("pmem_address", LW'(pmem_address), LW'(m_addr));
      check("pmem_wdata",   pmem_wdata, m_wdata);
      check("i_resp",       LW'(i_resp), LW'(m_responding && !m_is_d));
      check("d_resp",       LW'(d_resp), LW'(m_responding && m_is_d));
      check("i_rdata",      i_rdata, m_ir);
      check("d_rdata",      d_rdata, m_dr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [LW-1:0] a5, f0, line1, line2;

  initial begin
    a5 = {16{8'hA5}};
    f0 = {16{8'h0F}};

    // Reset state
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    check("rst_pmem_read", LW'(pmem_read), '0);
    check("rst_pmem_write", LW'(pmem_write), '0);
    check("rst_address", LW'(pmem_address), '0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    reset = 1'b0;

    // Instruction read with three busy cycles
    i_read = 1'b1; i_address = 16'h1230;
    step();
    for (int k = 0; k < 3; k++) begin
      check("i24_read", LW'(pmem_read), LW'(1));
      check("i24_addr", LW'(pmem_address), LW'(16'h1230));
      if (k == 2) begin pmem_resp = 1'b1; pmem_rdata = a5; end
      step();
    end
    pmem_resp = 1'b0;
    check("i24_resp", LW'(i_resp), LW'(1));
    check("i24_rdata", i_rdata, a5);
    check("i24_dresp", LW'(d_resp), '0);
    check("i24_read_off", LW'(pmem_read), '0);
    i_read = 1'b0;
    step();
    check("i24_resp_one", LW'(i_resp), '0);

    // Writeback with address changed mid-transaction
    d_write = 1'b1; d_address = 16'h4000; d_wdata = f0;
    step();
    check("d25_write", LW'(pmem_write), LW'(1));
    check("d25_noread", LW'(pmem_read), '0);
    d_address = 16'h5000; d_wdata = rnd_line();
    step();
    check("d25_addr_held", LW'(pmem_address), LW'(16'h4000));
    check("d25_wdata_held", pmem_wdata, f0);
    pmem_resp = 1'b1; pmem_rdata = rnd_line();
    step();
    pmem_resp = 1'b0;
    check("d25_resp", LW'(d_resp), LW'(1));
    check("d25_rdata_kept", d_rdata, '0);
    d_write = 1'b0;
    step();

    // Simultaneous requests: d first, idle gap, then i
    line1 = rnd_line(); line2 = rnd_line();
    i_read = 1'b1; i_address = 16'h3000;
    d_read = 1'b1; d_address = 16'h2000;
    step();
    check("p26_d_first", LW'(pmem_address), LW'(16'h2000));
    pmem_resp = 1'b1; pmem_rdata = line1;
    step();
    pmem_resp = 1'b0;
    check("p26_dresp", LW'(d_resp), LW'(1));
    check("p26_drdata", d_rdata, line1);
    d_read = 1'b0;
    step();
    check("p26_gap", LW'(pmem_read), '0);
    step();
    check("p26_i_addr", LW'(pmem_address), LW'(16'h3000));
    pmem_resp = 1'b1; pmem_rdata = line2;
    step();
    pmem_resp = 1'b0;
    check("p26_iresp", LW'(i_resp), LW'(1));
    check("p26_irdata", i_rdata, line2);
    i_read = 1'b0;
    step();

    // Reset in the second busy cycle, late memory response ignored
    d_read = 1'b1; d_address = 16'h7000;
    step();
    step();
    reset = 1'b1; d_read = 1'b0;
    step();
    reset = 1'b0; pmem_resp = 1'b1; pmem_rdata = rnd_line();
    check("r28_read", LW'(pmem_read), '0);
    check("r28_dresp", LW'(d_resp), '0);
    check("r28_drdata", d_rdata, '0);
    step();
    pmem_resp = 1'b0;
    check("r28_dresp2", LW'(d_resp), '0);
    check("r28_read2", LW'(pmem_read), '0);

    // Read and write together are a write
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h00F0; d_wdata = rnd_line();
    step();
    check("w29_write", LW'(pmem_write), LW'(1));
    check("w29_noread", LW'(pmem_read), '0);
    pmem_resp = 1'b1; pmem_rdata = rnd_line();
    step();
    pmem_resp = 1'b0;
    check("w29_resp", LW'(d_resp), LW'(1));
    check("w29_rdata", d_rdata, '0);
    d_read = 1'b0; d_write = 1'b0;
    step();

    // Randomized traffic, including stray responses and occasional resets
    for (int n = 0; n < 4000; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      i_read     = ($urandom_range(0, 2) != 0);
      d_read     = ($urandom_range(0, 2) == 0);
      d_write    = ($urandom_range(0, 3) == 0);
      i_address  = 16'($urandom());
      d_address  = 16'($urandom());
      d_wdata    = rnd_line();
      pmem_resp  = ($urandom_range(0, 3) == 0);
      pmem_rdata = rnd_line();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
